// File: rtl/hex_scan_driver.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : hex_scan_driver                                        |
// | Description : Time-multiplexed driver for eight seven-segment digits.|
// |               Snapshots all eight patterns once per frame and scans  |
// |               them onto one shared segment bus with active-low       |
// |               digit enables.                                         |
// | Option      : HEX_SCAN_BLANK_EN - when defined, every digit slot     |
// |               starts with BLANK_CYCLES of all-off (anti-ghosting).   |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module hex_scan_driver #(
  parameter int CLK_DIV      = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        enable_i,
  input  logic [31:0] hex0_i,
  input  logic [31:0] hex1_i,
  input  logic [31:0] hex2_i,
  input  logic [31:0] hex3_i,
  input  logic [31:0] hex4_i,
  input  logic [31:0] hex5_i,
  input  logic [31:0] hex6_i,
  input  logic [31:0] hex7_i,
  output logic [6:0]  seg_o,
  output logic [7:0]  an_o,
  output logic [2:0]  digit_idx_o,
  output logic        frame_done_o
);

  localparam int            CW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);
  localparam logic [6:0]    SEG_OFF  = 7'h7F;
  localparam logic [7:0]    AN_OFF   = 8'hFF;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BLANK = 2'd1,
    S_SHOW  = 2'd2
  } state_e;

`ifdef HEX_SCAN_BLANK_EN
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  // Every slot opens with the all-off interval.
  localparam state_e        SLOT_FIRST = S_BLANK;
`else
  // Without blanking a slot is pure SHOW and digits switch back-to-back.
  localparam state_e        SLOT_FIRST = S_SHOW;
`endif

  // Only the low seven bits of each processor register carry segment data.
  logic [6:0] hex_w [8];
  assign hex_w[0] = hex0_i[6:0];
  assign hex_w[1] = hex1_i[6:0];
  assign hex_w[2] = hex2_i[6:0];
  assign hex_w[3] = hex3_i[6:0];
  assign hex_w[4] = hex4_i[6:0];
  assign hex_w[5] = hex5_i[6:0];
  assign hex_w[6] = hex6_i[6:0];
  assign hex_w[7] = hex7_i[6:0];

  logic unused_hex_hi;
  assign unused_hex_hi = ^{hex0_i[31:7], hex1_i[31:7], hex2_i[31:7], hex3_i[31:7],
                           hex4_i[31:7], hex5_i[31:7], hex6_i[31:7], hex7_i[31:7]};

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [6:0]    snap_q [8];
  logic [6:0]    snap_d [8];
  logic          load_snap;
  logic          frame_done_d;
  logic [6:0]    seg_d;
  logic [7:0]    an_d;

  // Next-state logic: slot counter, digit index, snapshot capture and
  // the output values that the next state will present.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    frame_done_d = 1'b0;
    load_snap    = 1'b0;

    if (!enable_i) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      idx_d   = 3'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          // Fresh start always begins at digit 0 with a new snapshot.
          state_d   = SLOT_FIRST;
          cnt_d     = '0;
          idx_d     = 3'd0;
          load_snap = 1'b1;
        end
        default: begin
          if (cnt_q == CNT_LAST) begin
            state_d = SLOT_FIRST;
            cnt_d   = '0;
            idx_d   = idx_q + 3'd1;
            if (idx_q == 3'd7) begin
              // Frame boundary: the only point where new patterns are taken.
              frame_done_d = 1'b1;
              load_snap    = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
`ifdef HEX_SCAN_BLANK_EN
            if ((state_q == S_BLANK) && (cnt_q == BLANK_LAST)) begin
              state_d = S_SHOW;
            end
`endif
          end
        end
      endcase
    end

    for (int i = 0; i < 8; i++) begin
      snap_d[i] = load_snap ? hex_w[i] : snap_q[i];
    end

    if (state_d == S_SHOW) begin
      an_d  = ~(8'd1 << idx_d);
      seg_d = snap_d[idx_d];
    end else begin
      an_d  = AN_OFF;
      seg_d = SEG_OFF;
    end
  end

  // State, counters, snapshot and registered outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      idx_q        <= 3'd0;
      for (int i = 0; i < 8; i++) begin
        snap_q[i] <= SEG_OFF;
      end
      seg_o        <= SEG_OFF;
      an_o         <= AN_OFF;
      digit_idx_o  <= 3'd0;
      frame_done_o <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      for (int i = 0; i < 8; i++) begin
        snap_q[i] <= snap_d[i];
      end
      seg_o        <= seg_d;
      an_o         <= an_d;
      digit_idx_o  <= idx_d;
      frame_done_o <= frame_done_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hex_scan_driver.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_hex_scan_driver                                     |
// | Description : Directed self-checking bench for hex_scan_driver with  |
// |               CLK_DIV=8, BLANK_CYCLES=2. Expected blanking depends   |
// |               on HEX_SCAN_BLANK_EN.                                  |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_hex_scan_driver;

  localparam int CLK_DIV      = 8;
  localparam int BLANK_CYCLES = 2;
`ifdef HEX_SCAN_BLANK_EN
  localparam int BL = BLANK_CYCLES;
`else
  localparam int BL = 0;
`endif
  // Junk in the unused upper register bits must never reach the segments.
  localparam logic [24:0] JUNK = 25'h1A5A5A5;

  logic clk = 1'b0;
  logic rst_i;
  logic enable_i;
  logic [6:0] hv [8];
  logic [31:0] hex0_i, hex1_i, hex2_i, hex3_i, hex4_i, hex5_i, hex6_i, hex7_i;
  logic [6:0] seg_o;
  logic [7:0] an_o;
  logic [2:0] digit_idx_o;
  logic       frame_done_o;

  assign hex0_i = {JUNK, hv[0]};
  assign hex1_i = {JUNK, hv[1]};
  assign hex2_i = {JUNK, hv[2]};
  assign hex3_i = {JUNK, hv[3]};
  assign hex4_i = {JUNK, hv[4]};
  assign hex5_i = {JUNK, hv[5]};
  assign hex6_i = {JUNK, hv[6]};
  assign hex7_i = {JUNK, hv[7]};

  always #5 clk = ~clk;

  hex_scan_driver #(
    .CLK_DIV      (CLK_DIV),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) u_dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .enable_i     (enable_i),
    .hex0_i       (hex0_i),
    .hex1_i       (hex1_i),
    .hex2_i       (hex2_i),
    .hex3_i       (hex3_i),
    .hex4_i       (hex4_i),
    .hex5_i       (hex5_i),
    .hex6_i       (hex6_i),
    .hex7_i       (hex7_i),
    .seg_o        (seg_o),
    .an_o         (an_o),
    .digit_idx_o  (digit_idx_o),
    .frame_done_o (frame_done_o)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Packed view {frame_done, idx, an, seg} so one comparison covers all outputs.
  function automatic logic [31:0] pack(input logic fd, input logic [2:0] idx,
                                       input logic [7:0] an, input logic [6:0] seg);
    return {13'd0, fd, idx, an, seg};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] observed();
    return pack(frame_done_o, digit_idx_o, an_o, seg_o);
  endfunction

  localparam logic [31:0] IDLE_VEC = {13'd0, 1'b0, 3'd0, 8'hFF, 7'h7F};

  // Checks ncyc cycles of scanning. Cycle k=0 is the first cycle after the
  // edge that sees enable high out of IDLE. At k==chg_k hex3 is changed.
  task automatic scan_check(input string tag, input bit do_en, input int ncyc,
                            input int chg_k, input logic [6:0] chg_val);
    logic [6:0] fr [8];
    logic [7:0] an_e;
    logic [6:0] seg_e;
    int d;
    int pos;
    if (do_en) begin
      @(posedge clk);
      #1 enable_i = 1'b1;
    end
    @(posedge clk);
    for (int k = 0; k < ncyc; k++) begin
      @(negedge clk);
      if (k % (8 * CLK_DIV) == 0) fr = hv;
      d   = (k / CLK_DIV) % 8;
      pos = k % CLK_DIV;
      if (pos < BL) begin
        an_e  = 8'hFF;
        seg_e = 7'h7F;
      end else begin
        an_e  = ~(8'd1 << d);
        seg_e = fr[d];
      end
      check($sformatf("%s k=%0d", tag, k), observed(),
            pack((k > 0) && (k % (8 * CLK_DIV) == 0), 3'(d), an_e, seg_e));
      if (k == chg_k) hv[3] = chg_val;
    end
  endtask

  initial begin
    rst_i    = 1'b1;
    enable_i = 1'b0;
    for (int i = 0; i < 8; i++) hv[i] = 7'(i);

    // Reset and idle.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("reset_idle", observed(), IDLE_VEC);
    end
    @(posedge clk);
    #1 rst_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("idle_no_en", observed(), IDLE_VEC);
    end

    // Basic scan over two frames plus a little.
    scan_check("basic", 1'b1, 2 * 8 * CLK_DIV + 2, -1, 7'h00);
    enable_i = 1'b0;
    @(negedge clk);
    check("basic_off", observed(), IDLE_VEC);

    // Tear-free update: hex3 changes while digit 1 is shown.
    hv[0] = 7'h3F; hv[1] = 7'h06; hv[2] = 7'h5B; hv[3] = 7'h40;
    hv[4] = 7'h66; hv[5] = 7'h6D; hv[6] = 7'h7D; hv[7] = 7'h07;
    scan_check("tear", 1'b1, 8 * CLK_DIV + 8 * 4, CLK_DIV + 4, 7'h79);
    enable_i = 1'b0;
    @(negedge clk);
    check("tear_off", observed(), IDLE_VEC);

    // Disable during SHOW of digit 5, then re-enable.
    scan_check("dis_mid", 1'b1, 5 * CLK_DIV + 5, -1, 7'h00);
    enable_i = 1'b0;
    @(negedge clk);
    check("dis_next", observed(), IDLE_VEC);
    @(negedge clk);
    check("dis_hold", observed(), IDLE_VEC);
    scan_check("reen", 1'b1, 20, -1, 7'h00);

    // Asynchronous reset pulse between edges during SHOW of digit 2.
    @(negedge clk);
    check("pre_rst", observed(), pack(1'b0, 3'd2, 8'hFB, hv[2]));
    #2 rst_i = 1'b1;
    #1 check("async_rst", observed(), IDLE_VEC);
    #1 rst_i = 1'b0;
    scan_check("post_rst", 1'b0, 20, -1, 7'h00);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
